puf_crp_ctrl: RTL and testbench

PUF_CRP_CTRL -- requirements
Module: puf_crp_ctrl

---
 rtl/puf_pkg.sv | 19 +
 rtl/puf_crp_ctrl_gray_enc.sv | 13 +
 rtl/puf_crp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_puf_crp_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared definitions for the PUF challenge/response controller.
//   BYTE_W  - width of one UART byte
//   state_e - controller states
//   cnt_w   - counter width for a counter with tc distinct values (min 1)
package puf_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    EVAL = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic int cnt_w(input int tc);
    return (tc > 1) ? $clog2(tc) : 1;
  endfunction

endpackage

// File: rtl/puf_crp_ctrl_gray_enc.sv
// gray_enc: purely combinational binary-to-gray converter.
//   bin_i  [WIDTH-1:0]  binary input
//   gray_o [WIDTH-1:0]  gray[i] = bin[i] ^ bin[i+1], gray[MSB] = bin[MSB]
module gray_enc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/puf_crp_ctrl.sv
// puf_crp_ctrl: collects a challenge from a UART byte stream, drives it to a
// PUF core for SETTLE cycles, then streams the response (or, in check mode,
// the received binary challenge) back out byte by byte, LSB byte first.
//
// Ports
//   clk, rst            clock, async active-high reset
//   rx_data, rx_valid   incoming challenge bytes
//   check               loopback select, sampled with the final challenge byte
//   puf_challenge       registered challenge to the PUF core (gray or raw)
//   puf_en              PUF evaluate enable (EVAL only)
//   puf_response        PUF core output
//   tx_data, tx_valid   outgoing byte, held until tx_ready
//   tx_ready            transmitter accept
//   busy                high in EVAL and SEND
//   overrun             sticky: a byte arrived outside RECV
//
// state | meaning
// RECV  | accept challenge bytes into slot k
// EVAL  | puf_en high, settle down-counter running
// SEND  | present byte j of the shift register until accepted
module puf_crp_ctrl
  import puf_pkg::*;
#(
  parameter int CH_W    = 32,
  parameter int RSP_W   = 32,
  parameter int SETTLE  = 8,
  parameter int GRAY_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  input  logic               check,
  output logic [CH_W-1:0]    puf_challenge,
  output logic               puf_en,
  input  logic [RSP_W-1:0]   puf_response,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun
);

  localparam int CH_B  = CH_W / BYTE_W;
  localparam int RSP_B = RSP_W / BYTE_W;
  localparam int KW    = cnt_w(CH_B);
  localparam int JW    = cnt_w(RSP_B);
  localparam int SW    = cnt_w(SETTLE);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [JW-1:0]     j_q, j_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CH_W-1:0]   bin_q, bin_d;
  logic [CH_W-1:0]   chal_q, chal_d;
  logic [RSP_W-1:0]  sr_q, sr_d;
  logic              mode_q, mode_d;
  logic              ovr_q, ovr_d;

  logic [CH_W-1:0]   enc_w;
  logic [RSP_W-1:0]  echo_w;

  // Encode the next binary value so the challenge register is loaded with the
  // complete frame on the same edge that enters EVAL.
  generate
    if (GRAY_EN != 0) begin : g_gray
      gray_enc #(.WIDTH(CH_W)) u_gray (
        .bin_i  (bin_d),
        .gray_o (enc_w)
      );
    end else begin : g_raw
      assign enc_w = bin_d;
    end

    if (RSP_W > CH_W) begin : g_ext
      assign echo_w = {{(RSP_W-CH_W){1'b0}}, bin_q};
    end else begin : g_trunc
      assign echo_w = bin_q[RSP_W-1:0];
    end
  endgenerate

  assign chal_d = (state_q == RECV && state_d == EVAL) ? enc_w : chal_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    settle_d = settle_q;
    bin_d    = bin_q;
    sr_d     = sr_q;
    mode_d   = mode_q;
    ovr_d    = ovr_q | (rx_valid && state_q != RECV);

    case (state_q)
      RECV: begin
        if (rx_valid) begin
          bin_d[k_q*BYTE_W +: BYTE_W] = rx_data;
          if (k_q == KW'(CH_B-1)) begin
            k_d      = '0;
            mode_d   = check;
            settle_d = SW'(SETTLE-1);
            state_d  = EVAL;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (settle_q == '0) begin
          sr_d    = mode_q ? echo_w : puf_response;
          j_d     = '0;
          state_d = SEND;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (j_q == JW'(RSP_B-1)) begin
            j_d     = '0;
            state_d = RECV;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RECV;
      k_q      <= '0;
      j_q      <= '0;
      settle_q <= '0;
      bin_q    <= '0;
      chal_q   <= '0;
      sr_q     <= '0;
      mode_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      settle_q <= settle_d;
      bin_q    <= bin_d;
      chal_q   <= chal_d;
      sr_q     <= sr_d;
      mode_q   <= mode_d;
      ovr_q    <= ovr_d;
    end
  end

  assign puf_challenge = chal_q;
  assign puf_en        = (state_q == EVAL);
  assign tx_valid      = (state_q == SEND);
  assign busy          = (state_q != RECV);
  assign tx_data       = sr_q[j_q*BYTE_W +: BYTE_W];
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_puf_crp_ctrl.sv
module tb_puf_crp_ctrl;

  localparam logic [31:0] PUF_KEY0 = 32'hA5A5_1235;
  localparam logic [15:0] PUF_KEY1 = 16'h5A3C;

  logic clk, rst;

  // instance 0: defaults (32/32, SETTLE=8, gray)
  logic [7:0]  rx_data0;
  logic        rx_valid0, rx_last0, chk_in0;
  logic [31:0] chal0, resp0;
  logic        puf_en0, tx_valid0, tx_ready0, busy0, ovr0;
  logic [7:0]  tx_data0;

  // instance 1: 64-bit raw challenge, 16-bit response, SETTLE=1
  logic [7:0]  rx_data1;
  logic        rx_valid1, rx_last1, chk_in1;
  logic [63:0] chal1;
  logic [15:0] resp1;
  logic        puf_en1, tx_valid1, tx_ready1, busy1, ovr1;
  logic [7:0]  tx_data1;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;   // 0: ready always, 1: random, 2: held low
  int ncyc = 0;

  logic [31:0] chal_q0[$];
  logic [63:0] chal_q1[$];
  logic [7:0]  sb0[$];
  logic [7:0]  sb1[$];

  // PUF core models
  assign resp0 = chal0 ^ PUF_KEY0;
  assign resp1 = chal1[15:0] ^ chal1[63:48] ^ PUF_KEY1;

  puf_crp_ctrl dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0), .check(chk_in0),
    .puf_challenge(chal0), .puf_en(puf_en0), .puf_response(resp0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .busy(busy0), .overrun(ovr0)
  );

  puf_crp_ctrl #(.CH_W(64), .RSP_W(16), .SETTLE(1), .GRAY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1), .check(chk_in1),
    .puf_challenge(chal1), .puf_en(puf_en1), .puf_response(resp1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .overrun(ovr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // tx_ready drivers
  initial begin
    tx_ready0 = 1'b1;
    tx_ready1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready0 = 1'b1;
        1: tx_ready0 = 1'($urandom_range(0, 1));
        default: tx_ready0 = 1'b0;
      endcase
      tx_ready1 = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitors / scoreboards ----------------
  int strobe0 = -100, pen0 = 0;
  logic pvalid0 = 0, pready0 = 0;
  logic [7:0] pdata0 = 0;
  logic [31:0] cur_chal0 = 0;

  int strobe1 = -100, pen1 = 0;
  logic pvalid1 = 0, pready1 = 0;
  logic [7:0] pdata1 = 0;
  logic [63:0] cur_chal1 = 0;

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      // instance 0
      if (rx_valid0 && rx_last0) strobe0 = ncyc;
      if (puf_en0) begin
        if (pen0 == 0) begin
          compare("eval_expected0", 64'(chal_q0.size() != 0), 64'd1);
          if (chal_q0.size() != 0) cur_chal0 = chal_q0.pop_front();
          compare("challenge0", 64'(chal0), 64'(cur_chal0));
        end
        pen0++;
      end else if (pen0 != 0) begin
        compare("puf_en_len0", 64'(pen0), 64'd8);
        pen0 = 0;
      end
      if (tx_valid0 && !pvalid0) compare("latency0", 64'(ncyc - strobe0), 64'd9);
      if (pvalid0 && !pready0) begin
        compare("hold_valid0", 64'(tx_valid0), 64'd1);
        compare("hold_data0", 64'(tx_data0), 64'(pdata0));
      end
      if (tx_valid0 && tx_ready0) begin
        compare("tx_expected0", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) compare("tx_byte0", 64'(tx_data0), 64'(sb0.pop_front()));
        compare("chal_stable0", 64'(chal0), 64'(cur_chal0));
      end
      // instance 1
      if (rx_valid1 && rx_last1) strobe1 = ncyc;
      if (puf_en1) begin
        if (pen1 == 0) begin
          compare("eval_expected1", 64'(chal_q1.size() != 0), 64'd1);
          if (chal_q1.size() != 0) cur_chal1 = chal_q1.pop_front();
          compare("challenge1", chal1, cur_chal1);
        end
        pen1++;
      end else if (pen1 != 0) begin
        compare("puf_en_len1", 64'(pen1), 64'd1);
        pen1 = 0;
      end
      if (tx_valid1 && !pvalid1) compare("latency1", 64'(ncyc - strobe1), 64'd2);
      if (pvalid1 && !pready1) compare("hold_data1", 64'(tx_data1), 64'(pdata1));
      if (tx_valid1 && tx_ready1) begin
        compare("tx_expected1", 64'(sb1.size() != 0), 64'd1);
        if (sb1.size() != 0) compare("tx_byte1", 64'(tx_data1), 64'(sb1.pop_front()));
        compare("chal_stable1", chal1, cur_chal1);
      end
    end
    pvalid0 = tx_valid0; pready0 = tx_ready0; pdata0 = tx_data0;
    pvalid1 = tx_valid1; pready1 = tx_ready1; pdata1 = tx_data1;
  end

  // ---------------- stimulus ----------------
  // All drive tasks are entered just after a rising edge.
  task automatic send_byte0(input logic [7:0] b, input bit last, input bit md);
    rx_data0 = b; rx_valid0 = 1'b1; rx_last0 = last; chk_in0 = md;
    @(posedge clk); #1;
    rx_valid0 = 1'b0; rx_last0 = 1'b0;
  endtask

  task automatic send_byte1(input logic [7:0] b, input bit last, input bit md);
    rx_data1 = b; rx_valid1 = 1'b1; rx_last1 = last; chk_in1 = md;
    @(posedge clk); #1;
    rx_valid1 = 1'b0; rx_last1 = 1'b0;
  endtask

  task automatic send_frame0(input logic [31:0] bin, input bit md);
    logic [31:0] g, v;
    g = bin ^ (bin >> 1);
    v = md ? bin : (g ^ PUF_KEY0);
    chal_q0.push_back(g);
    for (int i = 0; i < 4; i++) sb0.push_back(v[i*8 +: 8]);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      send_byte0(bin[i*8 +: 8], i == 3, (i == 3) ? md : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame1(input logic [63:0] bin, input bit md);
    logic [15:0] v;
    v = md ? bin[15:0] : (bin[15:0] ^ bin[63:48] ^ PUF_KEY1);
    chal_q1.push_back(bin);
    for (int i = 0; i < 2; i++) sb1.push_back(v[i*8 +: 8]);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      send_byte1(bin[i*8 +: 8], i == 7, (i == 7) ? md : 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle0();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (sb0.size() == 0 && !busy0) done = 1;
    end
    compare("idle_reached0", 64'(done), 64'd1);
    compare("idle_outputs0", {62'd0, tx_valid0, puf_en0}, 64'd0);
  endtask

  task automatic wait_idle1();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (sb1.size() == 0 && !busy1) done = 1;
    end
    compare("idle_reached1", 64'(done), 64'd1);
    compare("idle_outputs1", {62'd0, tx_valid1, puf_en1}, 64'd0);
  endtask

  task automatic wait_tx0();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid0) seen = 1;
    end
    compare("tx_valid_seen0", 64'(seen), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    rx_data0 = 0; rx_valid0 = 0; rx_last0 = 0; chk_in0 = 0;
    rx_data1 = 0; rx_valid1 = 0; rx_last1 = 0; chk_in1 = 0;
    repeat (2) @(negedge clk);
    compare("rst_chal0", 64'(chal0), 64'd0);
    compare("rst_flags0", {59'd0, puf_en0, tx_valid0, busy0, ovr0, 1'b0}, 64'd0);
    compare("rst_txdata0", 64'(tx_data0), 64'd0);
    compare("rst_chal1", chal1, 64'd0);
    compare("rst_flags1", {59'd0, puf_en1, tx_valid1, busy1, ovr1, 1'b0}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed frames
    send_frame0(32'h0000_0001, 1'b0); wait_idle0();
    send_frame0(32'hDEAD_BEEF, 1'b1); wait_idle0();

    // transmitter stall on byte 0
    rdy_mode = 2;
    send_frame0($urandom, 1'b0);
    wait_tx0();
    repeat (20) @(negedge clk);
    rdy_mode = 0;
    wait_idle0();

    // random frames with random back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 6; n++) begin
      send_frame0($urandom, 1'($urandom_range(0, 1)));
      wait_idle0();
    end
    rdy_mode = 0;
    compare("no_overrun_yet0", 64'(ovr0), 64'd0);

    // overrun: byte in EVAL, byte on the completing SEND cycle
    send_frame0($urandom, 1'b0);
    send_byte0(8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    compare("overrun_eval0", 64'(ovr0), 64'd1);
    wait_tx0();
    repeat (3) begin @(posedge clk); #1; end
    send_byte0(8'hC3, 1'b0, 1'b1);
    wait_idle0();
    send_frame0($urandom, 1'b1); wait_idle0();
    send_frame0($urandom, 1'b0); wait_idle0();
    compare("overrun_sticky0", 64'(ovr0), 64'd1);

    // reset mid-frame
    @(posedge clk); #1;
    send_byte0(8'h11, 1'b0, 1'b0);
    send_byte0(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    compare("midrst_overrun0", 64'(ovr0), 64'd0);
    compare("midrst_flags0", {61'd0, tx_valid0, busy0, puf_en0}, 64'd0);
    compare("midrst_chal0", 64'(chal0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame0(32'h8765_4321, 1'b0); wait_idle0();
    send_frame0($urandom, 1'b1); wait_idle0();
    compare("overrun_after_rst0", 64'(ovr0), 64'd0);

    // wide-challenge / narrow-response instance
    send_frame1(64'h0123_4567_89AB_CDEF, 1'b0); wait_idle1();
    send_frame1(64'hFEDC_BA98_7654_3210, 1'b1); wait_idle1();
    for (int n = 0; n < 5; n++) begin
      send_frame1({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_idle1();
    end
    compare("overrun1", 64'(ovr1), 64'd0);
    compare("sb_drained", 64'(sb0.size() + sb1.size() + chal_q0.size() + chal_q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
